// File: rtl/converter_8_16_arbiter_if.sv
// converter_8_16_arbiter_if: requester operands, result handshake and status of the shared converter
interface converter_8_16_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] mag_in;
  logic [N_REQ-1:0]   sign_in;
  logic [N_REQ-1:0]   gnt;
  logic               busy;
  logic               out_valid;
  logic [15:0]        out_data;
  logic [ID_W-1:0]    out_id;
  logic               out_ready;
  logic [15:0]        conv_cnt;
  modport master (
    output req, mag_in, sign_in, out_ready,
    input  gnt, busy, out_valid, out_data, out_id, conv_cnt
  );
  modport slave (
    input  req, mag_in, sign_in, out_ready,
    output gnt, busy, out_valid, out_data, out_id, conv_cnt
  );
endinterface

// File: rtl/converter_8_16_arbiter.sv
// converter_8_16_arbiter: round-robin sharing of one sign/magnitude to two's-complement converter
module converter_8_16 (
  input  logic [7:0]  mag,
  input  logic        sign,
  output logic [15:0] data
);
  assign data = sign ? -{8'h00, mag} : {8'h00, mag};
endmodule

module converter_8_16_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input logic clk,
  input logic reset,
  converter_8_16_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;
  state_t          state, nxt;
  logic [ID_W-1:0] rr_ptr, win, idx, lat_id;
  logic [7:0]      lat_mag;
  logic            lat_sign, found;
  logic [15:0]     conv_data;
  converter_8_16 u_conv (.mag(lat_mag), .sign(lat_sign), .data(conv_data));
  // first pending requester at or after rr_ptr, wrapping modulo N_REQ
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && bus.req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    nxt = state;
    bus.gnt = '0;
    bus.busy = state != IDLE;
    if (state == IDLE) begin
      nxt = found ? CONV : IDLE;
      bus.gnt = found ? N_REQ'(1) << win : '0;
    end else if (state == CONV) begin
      nxt = HOLD;
    end else begin
      nxt = bus.out_ready ? IDLE : HOLD;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      lat_id <= '0;
      lat_mag <= '0;
      lat_sign <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_id <= '0;
      bus.conv_cnt <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && found) begin
        lat_id <= win;
        lat_mag <= bus.mag_in[8*win +: 8];
        lat_sign <= bus.sign_in[win];
      end
      if (state == CONV) begin
        bus.out_data <= conv_data;
        bus.out_id <= lat_id;
        bus.out_valid <= 1'b1;
      end
      if (state == HOLD && bus.out_ready) begin
        bus.out_valid <= 1'b0;
        bus.conv_cnt <= bus.conv_cnt + 16'd1;
        rr_ptr <= ID_W'((int'(bus.out_id) + 1) % N_REQ);
      end
    end
  end
endmodule

// File: tb/tb_converter_8_16_arbiter.sv
// tb_converter_8_16_arbiter: vector table, randomized transactions against a transaction-level model, corner sequences
module tb_converter_8_16_arbiter;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int ptr = 0;
  logic [15:0] exp_cnt = '0;
  always #5 clk = ~clk;
  converter_8_16_arbiter_if #(.N_REQ(4), .ID_W(2)) ifc ();
  converter_8_16_arbiter #(.N_REQ(4), .ID_W(2)) dut (.clk(clk), .reset(reset), .bus(ifc.slave));
  typedef struct {
    logic [3:0]  req;
    logic [31:0] mag;
    logic [3:0]  sign;
    logic [3:0]  gnt;
    logic [1:0]  id;
    logic [15:0] data;
  } vec_t;
  vec_t tbl [8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // starts one cycle after a rising edge with the DUT idle, returns the same way
  task automatic run_txn(input logic [3:0] r, input logic [31:0] m, input logic [3:0] s,
                         input logic [3:0] eg, input logic [1:0] eid, input logic [15:0] ed, input int hold);
    int w = 0;
    ifc.req = r; ifc.mag_in = m; ifc.sign_in = s; ifc.out_ready = 1'b0;
    @(negedge clk);
    while (ifc.gnt == '0 && w < 5) begin
      @(negedge clk);
      w++;
    end
    chk("gnt", {28'd0, ifc.gnt}, {28'd0, eg});
    chk("busy_idle", {31'd0, ifc.busy}, 0);
    @(posedge clk); #1;
    ifc.req = 4'($urandom); ifc.mag_in = $urandom; ifc.sign_in = 4'($urandom);
    @(negedge clk);
    chk("conv_gnt", {28'd0, ifc.gnt}, 0);
    chk("conv_busy", {31'd0, ifc.busy}, 1);
    chk("conv_valid", {31'd0, ifc.out_valid}, 0);
    @(posedge clk); #1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, ifc.out_valid}, 1);
      chk("hold_data", {16'd0, ifc.out_data}, {16'd0, ed});
      chk("hold_id", {30'd0, ifc.out_id}, {30'd0, eid});
      chk("hold_gnt", {28'd0, ifc.gnt}, 0);
      chk("hold_busy", {31'd0, ifc.busy}, 1);
      chk("hold_cnt", {16'd0, ifc.conv_cnt}, {16'd0, exp_cnt});
      @(posedge clk); #1;
    end
    ifc.out_ready = 1'b1; ifc.req = '0;
    @(negedge clk);
    chk("out_valid", {31'd0, ifc.out_valid}, 1);
    chk("out_data", {16'd0, ifc.out_data}, {16'd0, ed});
    chk("out_id", {30'd0, ifc.out_id}, {30'd0, eid});
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    exp_cnt++;
    ptr = (int'(eid) + 1) % 4;
    @(negedge clk);
    chk("done_valid", {31'd0, ifc.out_valid}, 0);
    chk("conv_cnt", {16'd0, ifc.conv_cnt}, {16'd0, exp_cnt});
    @(posedge clk); #1;
  endtask
  // expected winner and value straight from the round-robin and sign rules
  task automatic model_txn(input logic [3:0] r, input logic [31:0] m, input logic [3:0] s, input int hold);
    int w = -1;
    int val;
    logic [7:0] mv;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (ptr + k) % 4;
      if (w < 0 && r[i]) w = i;
    end
    mv = m[8*w +: 8];
    val = s[w] ? -int'(mv) : int'(mv);
    run_txn(r, m, s, 4'(1 << w), 2'(w), 16'(val), hold);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = '0;
    ptr = 0;
  endtask
  initial begin
    tbl[0] = '{4'b0001, 32'h00000007, 4'b0000, 4'b0001, 2'd0, 16'h0007};
    tbl[1] = '{4'b0001, 32'h00000007, 4'b0001, 4'b0001, 2'd0, 16'hFFF9};
    tbl[2] = '{4'b0001, 32'h000000FF, 4'b0001, 4'b0001, 2'd0, 16'hFF01};
    tbl[3] = '{4'b0001, 32'h00000000, 4'b0001, 4'b0001, 2'd0, 16'h0000};
    tbl[4] = '{4'b1111, 32'h44332211, 4'b0010, 4'b0010, 2'd1, 16'hFFDE};
    tbl[5] = '{4'b1001, 32'h80000000, 4'b1000, 4'b1000, 2'd3, 16'hFF80};
    tbl[6] = '{4'b0110, 32'h0000FE00, 4'b0000, 4'b0010, 2'd1, 16'h00FE};
    tbl[7] = '{4'b0011, 32'h000000FF, 4'b0001, 4'b0001, 2'd0, 16'hFF01};
    reset = 1'b1;
    ifc.req = '0; ifc.mag_in = '0; ifc.sign_in = '0; ifc.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("rst_gnt", {28'd0, ifc.gnt}, 0);
      chk("rst_busy", {31'd0, ifc.busy}, 0);
      chk("rst_valid", {31'd0, ifc.out_valid}, 0);
      chk("rst_cnt", {16'd0, ifc.conv_cnt}, 0);
      @(posedge clk); #1;
    end
    for (int v = 0; v < 8; v++)
      run_txn(tbl[v].req, tbl[v].mag, tbl[v].sign, tbl[v].gnt, tbl[v].id, tbl[v].data, v % 3);
    for (int n = 0; n < 40; n++)
      model_txn(4'($urandom_range(1, 15)), $urandom, 4'($urandom), $urandom_range(0, 3));
    model_txn(4'b0100, 32'h00C30000, 4'b0100, 20);
    model_txn(4'b0010, $urandom, 4'b0000, 0);
    ifc.req = 4'b1111; ifc.mag_in = 32'h000000AB; ifc.sign_in = '0;
    @(negedge clk);
    chk("pre_rst_gnt", {28'd0, ifc.gnt}, 32'h4);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("rconv_gnt", {28'd0, ifc.gnt}, 32'h1);
    chk("rconv_busy", {31'd0, ifc.busy}, 0);
    chk("rconv_valid", {31'd0, ifc.out_valid}, 0);
    chk("rconv_data", {16'd0, ifc.out_data}, 0);
    chk("rconv_id", {30'd0, ifc.out_id}, 0);
    chk("rconv_cnt", {16'd0, ifc.conv_cnt}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rhold_pre_data", {16'd0, ifc.out_data}, 32'h00AB);
    ifc.req = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rhold_busy", {31'd0, ifc.busy}, 0);
    chk("rhold_valid", {31'd0, ifc.out_valid}, 0);
    chk("rhold_data", {16'd0, ifc.out_data}, 0);
    chk("rhold_id", {30'd0, ifc.out_id}, 0);
    chk("rhold_gnt", {28'd0, ifc.gnt}, 0);
    @(posedge clk); #1;
    model_txn(4'b1010, 32'h00005A00, 4'b0010, 1);
    do_reset();
    ifc.req = 4'b1111; ifc.mag_in = $urandom; ifc.out_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("rr_gnt", {28'd0, ifc.gnt}, (k % 3 == 0) ? 32'(1 << ((k / 3) % 4)) : 0);
      if (k % 3 == 2) begin
        chk("rr_valid", {31'd0, ifc.out_valid}, 1);
        chk("rr_id", {30'd0, ifc.out_id}, 32'((k / 3) % 4));
      end
      @(posedge clk); #1;
    end
    ifc.req = '0; ifc.out_ready = 1'b0;
    exp_cnt = 16'd5;
    ptr = 1;
    @(negedge clk);
    chk("rr_cnt", {16'd0, ifc.conv_cnt}, 32'd5);
    @(posedge clk); #1;
    force ifc.conv_cnt = 16'hFFFF;
    @(negedge clk);
    release ifc.conv_cnt;
    exp_cnt = 16'hFFFF;
    @(posedge clk); #1;
    model_txn(4'b1000, 32'h01000000, 4'b1000, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
